fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 140 ++++++++++++++
 tb/tb_fifo_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a first-word-fall-through-less FIFO (data one
// cycle after rd_en) into a 2-entry skid buffer and presents them on a
// valid/ready stream. Build with FIFO_READER_STATS_EN defined to include the
// saturating rd_count / stall_count statistics; otherwise both read as 0.
module fifo_reader #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  underflow_err,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    localparam int unsigned DEPTH = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pending_q, pending_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  underflow_err_q, underflow_err_d;
    logic [FIFO_WIDTH-1:0] mem_q [DEPTH];

    logic                  pop_c;
    logic                  wr_c;
    logic                  room_c;
    logic [1:0]            fill_d;

    // Stream side: the head is only visible while something is buffered.
    assign m_valid       = !rst && (occ_q != 2'd0);
    assign m_data        = m_valid ? mem_q[rd_ptr_q] : '0;
    assign pop_c         = m_valid && m_ready;
    assign underflow_err = underflow_err_q;

    // A returning read is dropped when the FIFO flags underflow for it.
    assign wr_c = pending_q && !underflow;

    // HOLD means buffered plus in-flight words fill both slots; only a pop frees one.
    assign room_c = (state_q != ST_HOLD) || pop_c;
    assign rd_en  = !rst && en && !empty && room_c;

    // Next-state: occupancy, pointers, in-flight flag and FSM state.
    always_comb begin
        occ_d           = occ_q + 2'(wr_c) - 2'(pop_c);
        pending_d       = rd_en;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        underflow_err_d = underflow_err_q || underflow;
        state_d         = ST_RUN;

        if (wr_c) begin
            wr_ptr_d = !wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = !rd_ptr_q;
        end

        fill_d = occ_d + 2'(pending_d);
        case (fill_d)
            2'd0:    state_d = ST_IDLE;
            2'd1:    state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            occ_q           <= 2'd0;
            pending_q       <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            occ_q           <= occ_d;
            pending_q       <= pending_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    // Buffer storage; contents are don't-care until occupancy covers them.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= data_out;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // Saturating statistics: words delivered and cycles stalled by the sink.
    always_comb begin
        rd_count_d    = rd_count_q;
        stall_count_d = stall_count_q;
        if (pop_c && (rd_count_q != '1)) begin
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end
        if (m_valid && !m_ready && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            rd_count_q    <= rd_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rd_count    = rd_count_q;
    assign stall_count = stall_count_q;
`else
    assign rd_count    = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a behavioural FIFO model feeds the DUT,
// a per-cycle vector table covers short sequences, and hand-written loops
// cover streaming, backpressure and mid-transfer reset.
module tb_fifo_reader;

    localparam int unsigned FW = 16;
    localparam int unsigned CW = 16;
`ifdef FIFO_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          rd_en;
    logic [FW-1:0] data_out = '0;
    logic          empty = 1'b1;
    logic          underflow = 1'b0;
    logic          m_valid;
    logic [FW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          underflow_err;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] stall_count;

    fifo_reader #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .data_out(data_out),
        .empty(empty), .underflow(underflow), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .underflow_err(underflow_err), .rd_count(rd_count),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] fq[$];
    logic [FW-1:0] got_q[$];

    typedef struct {
        logic          first;
        int            nld;
        logic [FW-1:0] w;
        logic          en;
        logic          rdy;
        logic          uf;
        logic          e_rd;
        logic          e_mv;
        logic [FW-1:0] e_md;
        logic          e_err;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at the falling edge: record handshakes, cross the rising edge,
    // then let the FIFO model answer a read with data one cycle later.
    task automatic advance();
        logic rd_s;
        rd_s = rd_en;
        if (m_valid && m_ready) got_q.push_back(m_data);
        @(posedge clk);
        #1;
        if (rd_s && fq.size() > 0) data_out = fq.pop_front();
        empty = (fq.size() == 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        en = 1'b0;
        m_ready = 1'b0;
        underflow = 1'b0;
        fq.delete();
        got_q.delete();
        empty = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_rd_en", 32'(rd_en), 32'(0));
            chk("rst_m_valid", 32'(m_valid), 32'(0));
            chk("rst_m_data", 32'(m_data), 32'(0));
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        int rd_cycles, first_rd, last_rd, run, maxrun, w;
        logic [FW-1:0] hold_d;

        // A: single word; B: en drop after one read; C: underflow injection.
        tv[0]  = '{1'b1, 1, 16'hA5A5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[1]  = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[2]  = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0};
        tv[3]  = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[4]  = '{1'b1, 2, 16'h00B1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[5]  = '{1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[6]  = '{1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00B1, 1'b0};
        tv[7]  = '{1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[8]  = '{1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[9]  = '{1'b1, 1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[10] = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[11] = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[12] = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[13] = '{1'b0, 1, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        tv[14] = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[15] = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b1};
        tv[16] = '{1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};

        // Reset and idle.
        do_reset(3);
        @(negedge clk);
        chk("idle_rd_en", 32'(rd_en), 32'(0));
        chk("idle_m_valid", 32'(m_valid), 32'(0));
        chk("idle_m_data", 32'(m_data), 32'(0));
        chk("idle_uf_err", 32'(underflow_err), 32'(0));
        chk("idle_rd_count", 32'(rd_count), 32'(0));
        chk("idle_stall_count", 32'(stall_count), 32'(0));
        advance();

        // Table-driven per-cycle sequences.
        for (int i = 0; i < 17; i++) begin
            if (tv[i].first) do_reset(2);
            for (int k = 0; k < tv[i].nld; k++) fq.push_back(tv[i].w + FW'(k));
            if (tv[i].nld > 0) empty = 1'b0;
            en = tv[i].en;
            m_ready = tv[i].rdy;
            underflow = tv[i].uf;
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", i), 32'(rd_en), 32'(tv[i].e_rd));
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tv[i].e_mv));
            chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tv[i].e_md));
            chk($sformatf("vec%0d_uf_err", i), 32'(underflow_err), 32'(tv[i].e_err));
            advance();
        end
        underflow = 1'b0;
        do_reset(1);
        @(negedge clk);
        chk("uf_err_cleared", 32'(underflow_err), 32'(0));
        advance();

        // Streaming: eight words with a ready sink.
        do_reset(2);
        for (int i = 1; i <= 8; i++) fq.push_back(FW'(i));
        empty = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        rd_cycles = 0; first_rd = -1; last_rd = -1; run = 0; maxrun = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rd_en) begin
                rd_cycles++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            run = m_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            advance();
        end
        chk("stream_rd_cycles", 32'(rd_cycles), 32'(8));
        chk("stream_rd_span", 32'(last_rd - first_rd), 32'(7));
        chk("stream_valid_run", 32'(maxrun), 32'(8));
        chk("stream_count", 32'(got_q.size()), 32'(8));
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk($sformatf("stream_word%0d", i), 32'(got_q[i]), 32'(i + 1));
        @(negedge clk);
        chk("stream_rd_count", 32'(rd_count), STATS ? 32'(8) : 32'(0));
        advance();

        // Backpressure: five words, sink stalls for six valid cycles.
        do_reset(2);
        for (int i = 1; i <= 5; i++) fq.push_back(16'h0C00 + FW'(i));
        empty = 1'b0;
        en = 1'b1;
        m_ready = 1'b0;
        w = 0;
        @(negedge clk);
        while (!m_valid && w < 10) begin
            advance();
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", 32'(m_valid), 32'(1));
        hold_d = m_data;
        chk("bp_head", 32'(hold_d), 32'(16'h0C01));
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("bp_hold%0d_rd_en", k), 32'(rd_en), 32'(0));
            chk($sformatf("bp_hold%0d_m_data", k), 32'(m_data), 32'(hold_d));
            advance();
        end
        chk("bp_fifo_left", 32'(fq.size()), 32'(3));
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            advance();
        end
        chk("bp_count", 32'(got_q.size()), 32'(5));
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk($sformatf("bp_word%0d", i), 32'(got_q[i]), 32'(16'h0C01 + i));
        @(negedge clk);
        chk("bp_stall_count", 32'(stall_count), STATS ? 32'(6) : 32'(0));
        chk("bp_rd_count", 32'(rd_count), STATS ? 32'(5) : 32'(0));
        advance();

        // Reset in the middle of a transfer discards everything.
        do_reset(1);
        for (int i = 1; i <= 3; i++) fq.push_back(16'h0D00 + FW'(i));
        empty = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            advance();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid", 32'(m_valid), 32'(0));
        chk("midrst_rd_en", 32'(rd_en), 32'(0));
        chk("midrst_m_data", 32'(m_data), 32'(0));
        advance();
        rst = 1'b0;
        en = 1'b0;
        fq.delete();
        empty = 1'b1;
        @(negedge clk);
        chk("postrst_m_valid", 32'(m_valid), 32'(0));
        chk("postrst_m_data", 32'(m_data), 32'(0));
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
